// File: rtl/sort_readout.sv
// sort_readout -- streams a sorted memory out as a ready/valid element stream.
//
// When the sort controller reports done, the block reads addresses
// 0..DEPTH-1 from a synchronous-read memory once, buffers the returned data in
// a 2-entry FIFO and presents it on a ready/valid output with a last marker.
// One stream is produced per sort: sort_done must drop while idle before a
// new stream can start.
//
// Optional feature (compile-time macro READOUT_ORDER_CHECK_EN): unsigned
// check that the streamed elements are non-decreasing. A violation sets the
// sticky order_err flag. Without the macro, order_err is tied to 0.
//
// Ports:
//   clk, rst_n   - clock (rising edge), asynchronous active-low reset
//   sort_done    - level from the sort controller
//   rd_en        - memory read strobe, rd_addr - memory read address
//   rd_data      - memory read data, valid the cycle after rd_en
//   out_data     - streamed element, out_valid - element present
//   out_ready    - consumer accepts, out_last - element DEPTH-1
//   busy         - stream in progress, stream_done - one-cycle end pulse
//   order_err    - sticky ordering-violation flag
module sort_readout #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sort_done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              stream_done,
  output logic              order_err
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(DEPTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] CPLT = 2'd2;

  logic [1:0]        state_r;
  logic              armed_r;
  logic [CNT_W-1:0]  issue_cnt_r;
  logic [CNT_W-1:0]  out_cnt_r;
  logic [ADDR_W-1:0] issue_addr_r;
  logic              inflight_r;
  logic [DATA_W-1:0] fifo_mem_r [2];
  logic              wr_ptr_r;
  logic              rd_ptr_r;
  logic [1:0]        fifo_cnt_r;

  logic       start_s;
  logic       pop_s;
  logic       push_s;
  logic       issue_s;
  logic       last_xfer_s;
  logic [1:0] occ_s;

  // Stream-control decodes derived from the registered state
  always_comb begin
    start_s     = 1'b0;
    issue_s     = 1'b0;
    pop_s       = (fifo_cnt_r != 2'd0) && out_ready;
    push_s      = inflight_r;
    // Slots that will be held after this cycle: the element leaving now frees
    // its slot in time for a new read, which keeps full rate with 2 entries.
    occ_s       = fifo_cnt_r + {1'b0, inflight_r} - {1'b0, pop_s};
    last_xfer_s = pop_s && (out_cnt_r == LAST_C);
    if ((state_r == IDLE) && armed_r && sort_done) begin
      start_s = 1'b1;
    end else begin
      start_s = 1'b0;
    end
    if ((state_r == RUN) && (issue_cnt_r < DEPTH_C) && (occ_s < 2'd2)) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
  end

  // Control FSM and the one-stream-per-sort arming flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      armed_r <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_s) begin
            state_r <= RUN;
            armed_r <= 1'b0;
          end else if (!sort_done) begin
            armed_r <= 1'b1;
          end
        end
        RUN: begin
          if (last_xfer_s) begin
            state_r <= CPLT;
          end
        end
        CPLT:    state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  // Read-issue address/count, output transfer count and read-in-flight flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt_r  <= {CNT_W{1'b0}};
      issue_addr_r <= {ADDR_W{1'b0}};
      out_cnt_r    <= {CNT_W{1'b0}};
      inflight_r   <= 1'b0;
    end else begin
      inflight_r <= issue_s;
      if (start_s) begin
        issue_cnt_r  <= {CNT_W{1'b0}};
        issue_addr_r <= {ADDR_W{1'b0}};
        out_cnt_r    <= {CNT_W{1'b0}};
      end else begin
        if (issue_s) begin
          issue_cnt_r  <= issue_cnt_r + CNT_W'(1);
          issue_addr_r <= issue_addr_r + ADDR_W'(1);
        end
        if (pop_s) begin
          out_cnt_r <= out_cnt_r + CNT_W'(1);
        end
      end
    end
  end

  // Two-entry FIFO capturing memory data one cycle after each read strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_mem_r[0] <= {DATA_W{1'b0}};
      fifo_mem_r[1] <= {DATA_W{1'b0}};
      wr_ptr_r      <= 1'b0;
      rd_ptr_r      <= 1'b0;
      fifo_cnt_r    <= 2'd0;
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= rd_data;
        wr_ptr_r             <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + 2'd1;
        2'b01:   fifo_cnt_r <= fifo_cnt_r - 2'd1;
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
    end
  end

  assign rd_en       = issue_s;
  assign rd_addr     = issue_addr_r;
  assign out_valid   = (fifo_cnt_r != 2'd0);
  assign out_data    = fifo_mem_r[rd_ptr_r];
  assign out_last    = out_valid && (out_cnt_r == LAST_C);
  assign busy        = (state_r == RUN);
  assign stream_done = (state_r == CPLT);

`ifdef READOUT_ORDER_CHECK_EN
  logic [DATA_W-1:0] prev_r;
  logic              order_err_r;

  // Sticky check that each element after the first is not below its predecessor
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_r      <= {DATA_W{1'b0}};
      order_err_r <= 1'b0;
    end else if (pop_s) begin
      prev_r <= out_data;
      if ((out_cnt_r != {CNT_W{1'b0}}) && (out_data < prev_r)) begin
        order_err_r <= 1'b1;
      end
    end
  end

  assign order_err = order_err_r;
`else
  assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_sort_readout.sv
// Self-checking bench for sort_readout: a behavioural memory, randomized and
// patterned consumer back-pressure, and a queue-based reference of the stream.
module tb_sort_readout;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sort_done = 1'b0;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              out_last;
  logic              busy;
  logic              stream_done;
  logic              order_err;

  logic [DATA_W-1:0] mem [DEPTH];

  int vectors = 0;
  int miscompares = 0;
  bit exp_oerr = 1'b0;

  int first_rd;
  int first_valid;
  int first_xfer;
  int last_xfer;
  int n_xfer;
  int n_done;

  sort_readout #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .sort_done(sort_done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .stream_done(stream_done),
    .order_err(order_err)
  );

  always #5 clk = ~clk;

  // synchronous-read memory model
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  // Run one stream. mode: 0 ready=1, 1 ready pattern 1,0,0,1, 2 random ready.
  // stop_after>0 returns once that many transfers have been sampled.
  // hold_sd=0 drops sort_done right after the starting edge.
  task automatic run_stream(input int mode, input int stop_after, input bit hold_sd);
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] ex;
    logic [DATA_W-1:0] prev_data;
    logic [DATA_W-1:0] prev_x;
    bit prev_stall;
    bit oerr_next;
    bit finished;
    bit exp_done;
    int n_iss;
    prev_data = '0; prev_x = '0; prev_stall = 1'b0; finished = 1'b0; n_iss = 0;
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(mem[i]);
    first_rd = -1; first_valid = -1; first_xfer = -1; last_xfer = -100;
    n_xfer = 0; n_done = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(posedge clk); #1;
      if (!hold_sd && cyc == 0) sort_done = 1'b0;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: out_ready = 1'($urandom_range(1, 0));
      endcase
      @(negedge clk);
      oerr_next = exp_oerr;
      vectors++;
      if (order_err !== exp_oerr) begin
        miscompares++; $display("FAIL order_err cyc %0d: got %b want %b", cyc, order_err, exp_oerr);
      end
      if (busy !== (n_xfer < DEPTH)) begin
        miscompares++; $display("FAIL busy cyc %0d: got %b want %b", cyc, busy, (n_xfer < DEPTH));
      end
      exp_done = (n_xfer == DEPTH) && (cyc == last_xfer + 1);
      if (stream_done !== exp_done) begin
        miscompares++; $display("FAIL stream_done cyc %0d: got %b want %b", cyc, stream_done, exp_done);
      end
      if (stream_done === 1'b1) n_done++;
      if (rd_en === 1'b1) begin
        if (first_rd < 0) first_rd = cyc;
        if (n_iss >= DEPTH) begin
          miscompares++; $display("FAIL extra_issue cyc %0d: got addr %0d want no read", cyc, rd_addr);
        end else if (rd_addr !== ADDR_W'(n_iss)) begin
          miscompares++; $display("FAIL rd_addr cyc %0d: got %0d want %0d", cyc, rd_addr, n_iss);
        end
        n_iss++;
      end
      if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data)) begin
        miscompares++; $display("FAIL stall_hold cyc %0d: got %b/%0d want 1/%0d", cyc, out_valid, out_data, prev_data);
      end
      if (out_valid === 1'b1 && first_valid < 0) first_valid = cyc;
      if (out_valid === 1'b1 && out_ready) begin
        if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL extra_xfer cyc %0d: got %0d want none", cyc, out_data);
        end else begin
          ex = exp_q.pop_front();
          vectors++;
          if (out_data !== ex) begin
            miscompares++; $display("FAIL data #%0d: got %0d want %0d", n_xfer, out_data, ex);
          end
          if (out_last !== (n_xfer == DEPTH - 1)) begin
            miscompares++; $display("FAIL out_last #%0d: got %b want %b", n_xfer, out_last, (n_xfer == DEPTH - 1));
          end
`ifdef READOUT_ORDER_CHECK_EN
          if (n_xfer > 0 && out_data < prev_x) oerr_next = 1'b1;
`endif
          prev_x = out_data;
          if (first_xfer < 0) first_xfer = cyc;
          last_xfer = cyc;
          n_xfer++;
        end
      end
      if (n_iss - n_xfer > 2) begin
        miscompares++; $display("FAIL occupancy cyc %0d: got %0d want <=2", cyc, n_iss - n_xfer);
      end
      prev_stall = (out_valid === 1'b1) && !out_ready;
      prev_data = out_data;
      exp_oerr = oerr_next;
      if (stop_after > 0 && n_xfer == stop_after) begin finished = 1'b1; break; end
      if (n_xfer == DEPTH && cyc >= last_xfer + 4) begin finished = 1'b1; break; end
    end
    if (!finished) begin
      miscompares++; $display("FAIL timeout: got %0d transfers want %0d", n_xfer, DEPTH);
    end
  endtask

  task automatic start_sort();
    @(posedge clk); #1;
    sort_done = 1'b1;
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'(i + 1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({rd_en, rd_addr, out_data, out_valid, out_last, busy, stream_done, order_err} !== '0) begin
      miscompares++; $display("FAIL reset_outputs: got %b/%0d/%0d/%b/%b/%b/%b/%b want all 0",
                              rd_en, rd_addr, out_data, out_valid, out_last, busy, stream_done, order_err);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_full_rate();
    fill_ramp();
    start_sort();
    run_stream(0, 0, 1'b0);
    vectors++;
    if (first_rd != 0 || first_valid != 2) begin
      miscompares++; $display("FAIL latency: got rd %0d valid %0d want 0 2", first_rd, first_valid);
    end
    vectors++;
    if (n_xfer != DEPTH || last_xfer - first_xfer != DEPTH - 1) begin
      miscompares++; $display("FAIL full_rate: got %0d xfers over %0d cycles want %0d over %0d",
                              n_xfer, last_xfer - first_xfer + 1, DEPTH, DEPTH);
    end
    vectors++;
    if (n_done != 1) begin
      miscompares++; $display("FAIL done_count: got %0d want 1", n_done);
    end
  endtask

  task automatic test_backpressure();
    fill_ramp();
    start_sort();
    run_stream(1, 0, 1'b0);
    vectors++;
    if (n_xfer != DEPTH || n_done != 1) begin
      miscompares++; $display("FAIL backpressure: got %0d xfers %0d done want %0d 1", n_xfer, n_done, DEPTH);
    end
  endtask

  task automatic test_random_ready();
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'($urandom);
      start_sort();
      run_stream(2, 0, 1'b0);
      vectors++;
      if (n_xfer != DEPTH || n_done != 1) begin
        miscompares++; $display("FAIL random_ready %0d: got %0d xfers %0d done want %0d 1", r, n_xfer, n_done, DEPTH);
      end
    end
  endtask

  task automatic test_rearm();
    fill_ramp();
    start_sort();
    run_stream(0, 0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vectors++;
      if (rd_en !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
        miscompares++; $display("FAIL no_restart cyc %0d: got rd_en %b busy %b valid %b want 0", i, rd_en, busy, out_valid);
      end
    end
    @(posedge clk); #1;
    sort_done = 1'b0;
    repeat (2) @(posedge clk);
    start_sort();
    run_stream(0, 0, 1'b0);
    vectors++;
    if (n_xfer != DEPTH || first_rd != 0 || n_done != 1) begin
      miscompares++; $display("FAIL rearm: got %0d xfers first_rd %0d done %0d want %0d 0 1", n_xfer, first_rd, n_done, DEPTH);
    end
  endtask

  task automatic test_mid_reset();
    fill_ramp();
    start_sort();
    run_stream(0, 3, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_oerr = 1'b0;
    #1;
    vectors++;
    if ({rd_en, rd_addr, out_data, out_valid, out_last, busy, stream_done, order_err} !== '0) begin
      miscompares++; $display("FAIL mid_reset_outputs: got %b/%0d/%0d/%b/%b/%b/%b/%b want all 0",
                              rd_en, rd_addr, out_data, out_valid, out_last, busy, stream_done, order_err);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_stream(0, 0, 1'b0);
    vectors++;
    if (n_xfer != DEPTH || first_rd != 0 || first_valid != 2) begin
      miscompares++; $display("FAIL restart: got %0d xfers rd %0d valid %0d want %0d 0 2", n_xfer, first_rd, first_valid, DEPTH);
    end
  endtask

`ifdef READOUT_ORDER_CHECK_EN
  task automatic test_order_check();
    logic [DATA_W-1:0] bad [DEPTH];
    bad = '{8'd1, 8'd2, 8'd5, 8'd4, 8'd6, 8'd7, 8'd8, 8'd9};
    for (int i = 0; i < DEPTH; i++) mem[i] = bad[i];
    start_sort();
    run_stream(0, 0, 1'b0);
    vectors++;
    if (order_err !== 1'b1) begin
      miscompares++; $display("FAIL order_sticky: got %b want 1", order_err);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_oerr = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'd3;
    start_sort();
    run_stream(1, 0, 1'b0);
    vectors++;
    if (order_err !== 1'b0) begin
      miscompares++; $display("FAIL order_equal: got %b want 0", order_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full_rate();
    test_backpressure();
    test_random_ready();
    test_rearm();
    test_mid_reset();
`ifdef READOUT_ORDER_CHECK_EN
    test_order_check();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sort_readout.md
SORT_READOUT -- requirements
Module: sort_readout

Interface
REQ-001 SHALL have parameter DATA_W, default 8, element width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, number of sorted elements in memory (minimum 2).
REQ-003 SHALL have parameter ADDR_W, default 3, memory address width, with 2^ADDR_W >= DEPTH.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port sort_done, input, 1, level from the sort controller's done output.
REQ-007 SHALL have port rd_en, output, 1, memory read strobe.
REQ-008 SHALL have port rd_addr, output, ADDR_W, memory read address.
REQ-009 SHALL have port rd_data, input, DATA_W, memory read data, valid the cycle after rd_en (synchronous read).
REQ-010 SHALL have port out_data, output, DATA_W, streamed element.
REQ-011 SHALL have port out_valid, output, 1, out_data holds a valid element.
REQ-012 SHALL have port out_ready, input, 1, consumer accepts an element.
REQ-013 SHALL have port out_last, output, 1, the current element is element DEPTH-1.
REQ-014 SHALL have port busy, output, 1, high while in RUN.
REQ-015 SHALL have port stream_done, output, 1, one-cycle pulse after the last transfer.
REQ-016 SHALL have port order_err, output, 1, sticky ordering-violation flag (see Configuration).

Function
REQ-017 SHALL implement the states IDLE, RUN and CPLT.
REQ-018 In IDLE, with armed=1 and sort_done=1, SHALL move to RUN, clear the issue address and the output count, and set armed=0.
REQ-019 armed SHALL be set to 1 whenever sort_done=0 in IDLE, so each sort yields exactly one stream.
REQ-020 In RUN, rd_en SHALL be 1 only when issued < DEPTH and buffered + in-flight < 2, with rd_addr = issue address; the address SHALL increment after each issue.
REQ-021 rd_data SHALL be captured into a 2-entry FIFO on the cycle after each rd_en; data SHALL never be dropped or duplicated under any out_ready pattern.
REQ-022 out_valid SHALL equal FIFO non-empty and out_data SHALL equal the FIFO head; both SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 A transfer SHALL occur on any cycle where out_valid=1 and out_ready=1; out_last SHALL be 1 exactly on the transfer of element DEPTH-1.
REQ-024 Latency: if sort_done is sampled at edge E0, rd_en SHALL be high in the cycle after E0 and out_valid SHALL first be high after E2.
REQ-025 With out_ready held at 1, the block SHALL sustain one transfer per cycle.
REQ-026 After the last transfer, the block SHALL enter CPLT for one cycle with stream_done=1, then return to IDLE.
REQ-027 Deassertion of sort_done during RUN SHALL be ignored, and the stream SHALL complete.
REQ-028 Addresses SHALL run 0..DEPTH-1 in ascending order with no wrap; rd_en SHALL never be issued for an address >= DEPTH.

Reset
REQ-029 Asserting rst_n low at any time, including mid-stream, SHALL immediately force IDLE, armed=1, an empty FIFO, zero counters, order_err=0, and all outputs to 0.
REQ-030 After release of rst_n, a sort_done that is already high SHALL start a new stream from address 0.

Configuration
REQ-031 With READOUT_ORDER_CHECK_EN defined, each transferred element after the first SHALL be compared unsigned against the previous transferred element; if it is smaller, order_err SHALL set on the following cycle and hold until reset.
REQ-032 Without READOUT_ORDER_CHECK_EN defined, order_err SHALL be tied to 0 and no comparison logic SHALL be built.

Verification
REQ-033 Memory {1,2,3,4,5,6,7,8}, out_ready=1, pulse sort_done -> 8 transfers in 8 consecutive cycles, data 1..8, out_last on the value 8, then a single stream_done pulse.
REQ-034 Same memory, out_ready toggling 1,0,0,1 repeating -> data exactly 1..8 in order, out_data stable while stalled, rd_en never issued with 2 elements buffered or in flight.
REQ-035 sort_done held high after completion -> no second stream; drop then raise sort_done -> a second identical stream.
REQ-036 rst_n low after the 3rd transfer -> all outputs 0 at once; release with sort_done=1 -> stream restarts at element 1 (address 0).
REQ-037 With READOUT_ORDER_CHECK_EN defined, memory {1,2,5,4,6,7,8,9} -> order_err rises the cycle after the value-4 transfer and stays high; memory {3,3,3,3,3,3,3,3} -> order_err stays 0.
